// File: rtl/adc_stream_capture.sv
// ADC stream capture: triggered burst of stream beats into block RAM, sample readback 2 cycles after an address change.
// Never back-pressures (TREADY held high out of reset); define ADC_CAPTURE_DECIMATE_EN to keep every (D+1)th beat.
module adc_stream_capture #(
   parameter int BUS_WIDTH         = 32,
   parameter int AXIS_DATA_WIDTH   = 256,
   parameter int ADC_DATA_WIDTH    = 16,
   parameter int ADC_ADDRESS_WIDTH = 14
) (
   input  logic                       axis_CLK,
   input  logic                       axis_RESETN,
   input  logic [AXIS_DATA_WIDTH-1:0] axis_TDATA,
   input  logic                       axis_TVALID,
   output logic                       axis_TREADY,
   input  logic                       hbMarker,
   input  logic [BUS_WIDTH-1:0]       gpioData,
   input  logic                       gpioStrobe,
   input  logic                       gpioAddressStrobe,
   input  logic                       gpioReadStrobe,
   output logic [BUS_WIDTH-1:0]       gpioCsr,
   output logic [BUS_WIDTH-1:0]       gpioReadData
);
   localparam int SPB = AXIS_DATA_WIDTH / ADC_DATA_WIDTH;
   localparam int LW  = $clog2(SPB);
   localparam int WA  = ADC_ADDRESS_WIDTH - LW;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t                       state;
   logic [WA-1:0]                lastIdx;
   logic [WA:0]                  wordCount;
   logic [ADC_ADDRESS_WIDTH-1:0] readAddr;
   logic                         hbD1;
   logic                         trigSrc;
   logic [LW-1:0]                laneSel;
   logic [AXIS_DATA_WIDTH-1:0]   ramQ;
   logic [AXIS_DATA_WIDTH-1:0]   mem [2**WA];
   logic [ADC_DATA_WIDTH-1:0]    sample;
   logic [3:0]                   decimField;

   logic ctrlWr, armBit, swTrig, hbEdge, idleOrDone, beatKeep, storeBeat, hitLast;
   logic unusedBits;

   assign ctrlWr     = gpioStrobe & gpioData[BUS_WIDTH-1];
   assign armBit     = gpioData[0];
   assign swTrig     = ctrlWr & gpioData[1];
   assign hbEdge     = hbMarker & ~hbD1;
   assign idleOrDone = (state == IDLE) || (state == DONE);
   assign hitLast    = (wordCount == {1'b0, lastIdx});
   assign unusedBits = ^gpioData;

`ifdef ADC_CAPTURE_DECIMATE_EN
   logic [3:0] decim;
   logic [3:0] decimCnt;
   assign beatKeep   = (decimCnt == 4'd0);
   assign decimField = decim;
`else
   assign beatKeep   = 1'b1;
   assign decimField = 4'd0;
`endif

   assign storeBeat = (state == CAPTURE) && axis_TVALID && axis_TREADY && beatKeep;

   always_ff @(posedge axis_CLK or negedge axis_RESETN) begin
      if (!axis_RESETN) begin
         state       <= IDLE;
         lastIdx     <= '1;
         wordCount   <= '0;
         hbD1        <= 1'b0;
         trigSrc     <= 1'b0;
         axis_TREADY <= 1'b0;
`ifdef ADC_CAPTURE_DECIMATE_EN
         decim       <= 4'd0;
         decimCnt    <= 4'd0;
`endif
      end else begin
         axis_TREADY <= 1'b1;
         hbD1        <= hbMarker;
         if (gpioStrobe && !gpioData[BUS_WIDTH-1] && idleOrDone)
            lastIdx <= gpioData[WA-1:0];
`ifdef ADC_CAPTURE_DECIMATE_EN
         if (ctrlWr && idleOrDone)
            decim <= gpioData[7:4];
         if ((state == CAPTURE) && axis_TVALID && axis_TREADY)
            decimCnt <= (decimCnt == decim) ? 4'd0 : decimCnt + 4'd1;
`endif
         if (storeBeat)
            wordCount <= wordCount + 1'b1;

         // Disarm wins over everything; buffer and wordCount are left intact.
         if (ctrlWr && !armBit) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (ctrlWr) begin
                     if (swTrig) begin
                        state     <= CAPTURE;
                        wordCount <= '0;
                        trigSrc   <= 1'b0;
`ifdef ADC_CAPTURE_DECIMATE_EN
                        decimCnt  <= 4'd0;
`endif
                     end else begin
                        state <= ARMED;
                        if (state == DONE)
                           wordCount <= '0;
                     end
                  end
               end
               ARMED: begin
                  if (swTrig || hbEdge) begin
                     state     <= CAPTURE;
                     wordCount <= '0;
                     trigSrc   <= hbEdge & ~swTrig;
`ifdef ADC_CAPTURE_DECIMATE_EN
                     decimCnt  <= 4'd0;
`endif
                  end
               end
               CAPTURE: begin
                  if (storeBeat && hitLast)
                     state <= DONE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge axis_CLK) begin
      if (storeBeat)
         mem[wordCount[WA-1:0]] <= axis_TDATA;
      ramQ <= mem[readAddr[ADC_ADDRESS_WIDTH-1:LW]];
   end

   assign sample = ramQ[laneSel*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];

   // laneSel lags readAddr by one cycle so it lines up with the registered RAM word.
   always_ff @(posedge axis_CLK or negedge axis_RESETN) begin
      if (!axis_RESETN) begin
         readAddr     <= '0;
         laneSel      <= '0;
         gpioReadData <= '0;
      end else begin
         if (gpioAddressStrobe)
            readAddr <= gpioData[ADC_ADDRESS_WIDTH-1:0];
         else if (gpioReadStrobe)
            readAddr <= readAddr + 1'b1;
         laneSel      <= readAddr[LW-1:0];
         gpioReadData <= {{(BUS_WIDTH-ADC_DATA_WIDTH){sample[ADC_DATA_WIDTH-1]}}, sample};
      end
   end

   always_comb begin
      gpioCsr          = '0;
      gpioCsr[0]       = (state == ARMED) || (state == CAPTURE);
      gpioCsr[1]       = (state == CAPTURE);
      gpioCsr[2]       = (state == DONE);
      gpioCsr[3]       = trigSrc;
      gpioCsr[7:4]     = decimField;
      gpioCsr[8 +: WA] = wordCount[WA-1:0];
   end

endmodule

// File: tb/tb_adc_stream_capture.sv
// Directed bench for adc_stream_capture: burst capture, TVALID gaps, sign-extended readback,
// disarm/reset mid-capture, heartbeat edge qualification and (when built with it) decimation.
module tb_adc_stream_capture;
   logic         axis_CLK;
   logic         axis_RESETN;
   logic [255:0] axis_TDATA;
   logic         axis_TVALID;
   logic         axis_TREADY;
   logic         hbMarker;
   logic [31:0]  gpioData;
   logic         gpioStrobe;
   logic         gpioAddressStrobe;
   logic         gpioReadStrobe;
   logic [31:0]  gpioCsr;
   logic [31:0]  gpioReadData;

   int checks   = 0;
   int failures = 0;

   adc_stream_capture dut (
      .axis_CLK          (axis_CLK),
      .axis_RESETN       (axis_RESETN),
      .axis_TDATA        (axis_TDATA),
      .axis_TVALID       (axis_TVALID),
      .axis_TREADY       (axis_TREADY),
      .hbMarker          (hbMarker),
      .gpioData          (gpioData),
      .gpioStrobe        (gpioStrobe),
      .gpioAddressStrobe (gpioAddressStrobe),
      .gpioReadStrobe    (gpioReadStrobe),
      .gpioCsr           (gpioCsr),
      .gpioReadData      (gpioReadData)
   );

   initial axis_CLK = 1'b0;
   always #5 axis_CLK = ~axis_CLK;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge axis_CLK);
      #1;
   endtask

   function automatic logic [255:0] mkBeat(input int n);
      logic [255:0] b;
      for (int k = 0; k < 16; k++)
         b[16*k +: 16] = 16'(n*16 + k);
      return b;
   endfunction

   task automatic ctrlWrite(input logic [31:0] d);
      gpioData   = d;
      gpioStrobe = 1'b1;
      tick();
      gpioStrobe = 1'b0;
   endtask

   task automatic sendBeat(input logic [255:0] d, input logic vld);
      axis_TDATA  = d;
      axis_TVALID = vld;
      tick();
      axis_TVALID = 1'b0;
   endtask

   // Loads the read address and waits the two-cycle read latency.
   task automatic setAddr(input logic [31:0] a);
      gpioData          = a;
      gpioAddressStrobe = 1'b1;
      tick();
      gpioAddressStrobe = 1'b0;
      tick();
      tick();
   endtask

   task automatic readNext();
      gpioReadStrobe = 1'b1;
      tick();
      gpioReadStrobe = 1'b0;
      tick();
      tick();
   endtask

   logic [255:0] beat;

   initial begin
      axis_RESETN       = 1'b0;
      axis_TDATA        = '0;
      axis_TVALID       = 1'b0;
      hbMarker          = 1'b0;
      gpioData          = '0;
      gpioStrobe        = 1'b0;
      gpioAddressStrobe = 1'b0;
      gpioReadStrobe    = 1'b0;
      repeat (3) tick();
      checkVal("rst_tready", {31'd0, axis_TREADY}, 32'd0);
      checkVal("rst_csr", gpioCsr, 32'h0);
      checkVal("rst_rdata", gpioReadData, 32'h0);
      axis_RESETN = 1'b1;
      tick();
      checkVal("tready_after_rst", {31'd0, axis_TREADY}, 32'd1);

      // Heartbeat-triggered burst of 4 words, extra beats discarded.
      ctrlWrite(32'd3);
      ctrlWrite(32'h8000_0001);
      checkVal("t1_armed", gpioCsr, 32'h001);
      hbMarker = 1'b1;
      tick();
      checkVal("t1_capture_hb", gpioCsr, 32'h00B);
      for (int n = 0; n < 4; n++) sendBeat(mkBeat(n), 1'b1);
      checkVal("t1_done", gpioCsr, 32'h40C);
      sendBeat(mkBeat(4), 1'b1);
      sendBeat(mkBeat(5), 1'b1);
      hbMarker = 1'b0;
      checkVal("t1_done_after_extra", gpioCsr, 32'h40C);
      setAddr(32'd0);
      for (int i = 0; i < 64; i++) begin
         checkVal($sformatf("t1_read_%0d", i), gpioReadData, 32'(i));
         if (i < 63) readNext();
      end

      // Arm+software trigger in one write, TVALID toggling.
      ctrlWrite(32'd2);
      ctrlWrite(32'h8000_0003);
      checkVal("t2_capture_sw", gpioCsr, 32'h003);
      sendBeat(mkBeat(10), 1'b1);
      sendBeat(mkBeat(11), 1'b0);
      checkVal("t2_tready_gap", {31'd0, axis_TREADY}, 32'd1);
      sendBeat(mkBeat(12), 1'b1);
      sendBeat(mkBeat(13), 1'b0);
      checkVal("t2_count2", gpioCsr, 32'h203);
      sendBeat(mkBeat(14), 1'b1);
      checkVal("t2_done", gpioCsr, 32'h304);
      checkVal("t2_tready", {31'd0, axis_TREADY}, 32'd1);
      setAddr(32'd0);
      checkVal("t2_word0", gpioReadData, 32'd160);
      setAddr(32'd16);
      checkVal("t2_word1", gpioReadData, 32'd192);
      setAddr(32'd32);
      checkVal("t2_word2", gpioReadData, 32'd224);

      // Sign extension and exact two-cycle read latency.
      ctrlWrite(32'd0);
      ctrlWrite(32'h8000_0003);
      beat = mkBeat(0);
      beat[15:0]  = 16'h8001;
      beat[31:16] = 16'h7FFE;
      sendBeat(beat, 1'b1);
      checkVal("t3_done", gpioCsr, 32'h104);
      gpioData          = 32'd0;
      gpioAddressStrobe = 1'b1;
      tick();
      gpioAddressStrobe = 1'b0;
      tick();
      checkVal("t3_latency_old", gpioReadData, 32'h0000_00E0);
      tick();
      checkVal("t3_sext", gpioReadData, 32'hFFFF_8001);
      readNext();
      checkVal("t3_lane1", gpioReadData, 32'h0000_7FFE);

      // lastIdx write ignored in CAPTURE, rearm from DONE, disarm, reset mid-capture.
      ctrlWrite(32'd3);
      ctrlWrite(32'h8000_0003);
      sendBeat(mkBeat(20), 1'b1);
      ctrlWrite(32'd1);
      sendBeat(mkBeat(21), 1'b1);
      sendBeat(mkBeat(22), 1'b1);
      checkVal("t4_lastidx_ignored", gpioCsr, 32'h303);
      sendBeat(mkBeat(23), 1'b1);
      checkVal("t4_done_old_last", gpioCsr, 32'h404);
      ctrlWrite(32'h8000_0001);
      checkVal("t4_rearm_clears", gpioCsr, 32'h001);
      ctrlWrite(32'h8000_0003);
      sendBeat(mkBeat(24), 1'b1);
      sendBeat(mkBeat(25), 1'b1);
      checkVal("t4_mid", gpioCsr, 32'h203);
      ctrlWrite(32'h8000_0000);
      checkVal("t4_disarm", gpioCsr, 32'h200);
      sendBeat(mkBeat(26), 1'b1);
      checkVal("t4_idle_discard", gpioCsr, 32'h200);
      ctrlWrite(32'h8000_0003);
      sendBeat(mkBeat(27), 1'b1);
      checkVal("t4_recapture", gpioCsr, 32'h103);
      axis_RESETN = 1'b0;
      #1;
      checkVal("t4_rst_tready", {31'd0, axis_TREADY}, 32'd0);
      checkVal("t4_rst_csr", gpioCsr, 32'h0);
      tick();
      axis_RESETN = 1'b1;
      tick();
      checkVal("t4_tready_back", {31'd0, axis_TREADY}, 32'd1);

      // Heartbeat held high across arm needs a fresh edge; heartbeat in DONE is ignored.
      ctrlWrite(32'd0);
      hbMarker = 1'b1;
      tick();
      tick();
      ctrlWrite(32'h8000_0001);
      repeat (3) tick();
      checkVal("t5_no_level_trig", gpioCsr, 32'h001);
      hbMarker = 1'b0;
      tick();
      hbMarker = 1'b1;
      tick();
      checkVal("t5_edge_trig", gpioCsr, 32'h00B);
      sendBeat(mkBeat(30), 1'b1);
      checkVal("t5_done", gpioCsr, 32'h10C);
      hbMarker = 1'b0;
      tick();
      hbMarker = 1'b1;
      tick();
      sendBeat(mkBeat(31), 1'b1);
      checkVal("t5_hb_in_done", gpioCsr, 32'h10C);
      setAddr(32'd0);
      checkVal("t5_word0", gpioReadData, 32'h1E0);
      hbMarker = 1'b0;

      // Decimation field D=2 in the same arm+trigger write.
      ctrlWrite(32'd2);
      ctrlWrite(32'h8000_0023);
`ifdef ADC_CAPTURE_DECIMATE_EN
      checkVal("t6_csr_dec", gpioCsr, 32'h023);
      for (int n = 0; n < 9; n++) sendBeat(mkBeat(n), 1'b1);
      checkVal("t6_done_dec", gpioCsr, 32'h324);
      setAddr(32'd16);
      checkVal("t6_word1", gpioReadData, 32'd48);
      setAddr(32'd32);
      checkVal("t6_word2", gpioReadData, 32'd96);
`else
      checkVal("t6_csr_nodec", gpioCsr, 32'h003);
      for (int n = 0; n < 9; n++) sendBeat(mkBeat(n), 1'b1);
      checkVal("t6_done_nodec", gpioCsr, 32'h304);
      setAddr(32'd16);
      checkVal("t6_word1", gpioReadData, 32'd16);
      setAddr(32'd32);
      checkVal("t6_word2", gpioReadData, 32'd32);
`endif
      setAddr(32'd0);
      checkVal("t6_word0", gpioReadData, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adc_stream_capture.md
Name: adc_stream_capture

Overview:
- AXI-Stream receiver and capture buffer for ADC sample data; the counterpart of the DAC table streamer, in the opposite direction.
- Accepts wide multi-sample beats on axis_TDATA and stores a triggered burst in block RAM. The trigger is the EVR heartbeat rising edge or a software trigger.
- The processor reads samples back one at a time through a GPIO-style CSR/data interface.
- Single clock domain. The heartbeat marker arrives already synchronised to axis_CLK.

Parameters:
- BUS_WIDTH, 32, GPIO/CSR width.
- AXIS_DATA_WIDTH, 256, stream beat width.
- ADC_DATA_WIDTH, 16, bits per sample. SAMPLES_PER_BEAT = AXIS_DATA_WIDTH/ADC_DATA_WIDTH.
- ADC_ADDRESS_WIDTH, 14, sample address width. Word address width WA = ADC_ADDRESS_WIDTH - log2(SAMPLES_PER_BEAT), which is 10 at defaults.

Ports:
- axis_CLK, in, 1, sole clock.
- axis_RESETN, in, 1, asynchronous active-low reset.
- axis_TDATA, in, AXIS_DATA_WIDTH, sample beat. Lane k is bits [16k+15:16k]; lane 0 is the earliest sample.
- axis_TVALID, in, 1, beat valid.
- axis_TREADY, out, 1, beat accept.
- hbMarker, in, 1, EVR heartbeat level, synchronous to axis_CLK.
- gpioData, in, BUS_WIDTH, write data.
- gpioStrobe, in, 1, CSR write.
- gpioAddressStrobe, in, 1, load read address.
- gpioReadStrobe, in, 1, advance read address.
- gpioCsr, out, BUS_WIDTH, status.
- gpioReadData, out, BUS_WIDTH, sample at the read address, sign-extended.

Behaviour:
- Reset:
  - axis_TREADY=0 while reset is asserted; it is 1 from the first clock after deassertion and stays 1.
  - Other reset values: state=IDLE, lastIdx=all ones, wordCount=0, readAddr=0, gpioReadData=0, hb edge registers=0.
  - Buffer contents are undefined after reset.
- Heartbeat edge: hbEdge = hbMarker & !hb_d1, where hb_d1 is registered.
- gpioStrobe with gpioData[31]=1 (control):
  - bit0 arm. bit0=0 sends any state to IDLE and clears done; buffer and wordCount are kept.
  - bit1 software trigger, a one-cycle pulse.
- gpioStrobe with gpioData[31]=0 sets lastIdx=gpioData[WA-1:0]. This write is accepted only in IDLE or DONE and is ignored otherwise.
- States:
  - IDLE --arm--> ARMED.
  - ARMED --(hbEdge | swTrig)--> CAPTURE, with wordCount cleared.
  - CAPTURE stores each beat where TVALID&TREADY at word wordCount, then increments wordCount. The beat stored at wordCount==lastIdx moves the state to DONE the next cycle.
  - DONE --arm write--> ARMED, clearing wordCount.
- Simultaneous arm + trigger in one control write (from IDLE or DONE) goes straight to CAPTURE.
- Triggers arriving in IDLE, CAPTURE or DONE are ignored.
- The first stored beat is the first valid beat on the cycle after the state enters CAPTURE.
- Beats arriving outside CAPTURE are accepted and discarded. The block never back-pressures.
- A TVALID gap during CAPTURE simply stalls counting. wordCount never exceeds lastIdx+1.
- Capture length is lastIdx+1 words. lastIdx=0 captures exactly one beat.
- Readback:
  - gpioAddressStrobe loads readAddr=gpioData[ADC_ADDRESS_WIDTH-1:0].
  - gpioReadStrobe does readAddr+1, wrapping modulo 2^ADC_ADDRESS_WIDTH.
  - Word = readAddr[ADC_ADDRESS_WIDTH-1:4]; lane = readAddr[3:0].
  - gpioReadData is valid 2 cycles after an address change (registered RAM read, then registered lane mux).
  - Reads during CAPTURE return whatever the RAM holds. No protection is provided.
- gpioCsr bit fields:
  - [0] armed (ARMED|CAPTURE).
  - [1] capturing.
  - [2] done.
  - [3] last trigger source, 1=heartbeat, 0=software.
  - [7:4] decimation (see optional feature), else 0.
  - [8+:WA] wordCount.
  - Remaining bits 0.
- Reset mid-capture returns to IDLE with wordCount=0. The partial buffer is undefined.

Optional Feature:
- ADC_CAPTURE_DECIMATE_EN defined:
  - Control bits [7:4] set D. Writing them is accepted only in IDLE or DONE.
  - In CAPTURE, only every (D+1)th valid beat is stored. The first valid beat after the trigger is always stored.
  - The decimation counter clears on entry to CAPTURE.
  - gpioCsr[7:4] reads back D.
- ADC_CAPTURE_DECIMATE_EN undefined: bits [7:4] are ignored and read 0, and every valid beat is stored.

Test Plan:
- Set lastIdx=3, arm, pulse hbMarker, stream 6 beats with lane k of beat n = n*16+k -> done=1, wordCount=4. Reading readAddr=0..63 returns 0..63; beats 4 and 5 are discarded. Trigger source bit = 1.
- Arm+swTrig in one write, TVALID toggling 1,0,1,0 -> only valid beats are stored, contiguously; done after lastIdx+1 valid beats; TREADY stays 1.
- Lane 0 = 0x8001 at word 0, then gpioAddressStrobe with 0 -> gpioReadData=0xFFFF8001 exactly two cycles later. gpioReadStrobe -> lane 1 value.
- In CAPTURE, write lastIdx=1 -> ignored, capture runs to the old lastIdx. Write disarm mid-capture -> IDLE, wordCount frozen. Assert axis_RESETN low mid-capture -> IDLE, TREADY=0, wordCount=0.
- hbMarker held high across arm -> no trigger until a fresh low-to-high edge. A heartbeat during DONE does not restart capture.
- With ADC_CAPTURE_DECIMATE_EN and D=2, stream beats 0..8 -> beats 0, 3, 6 are stored at words 0, 1, 2.
